// File: rtl/neg_pipe.sv
// neg_pipe: pipelined two's-complement pass / negate / abs unit.
// Negation uses the XOR/OR-propagate form out[i] = x[i] ^ (x[i-1] | ... | x[0]).
// The OR chain is cut into STAGES equal segments, one segment per register stage.
// The negate decision and the running OR ("seen") travel down the pipe with the word.
// A single global advance signal stalls or shifts every stage together.
module neg_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SEG = WIDTH / STAGES;

  // Index k of these buses is the state presented to the input of stage k.
  // Index 0 comes from the input port; index k+1 comes from stage k's registers.
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_neg;
  logic [STAGES-1:0] w_seen;
  logic [WIDTH-1:0]  w_d [STAGES];

  logic             w_adv;
  logic             w_in_neg;

  // Last-stage registers drive the output port directly
  logic             r_out_v;
  logic [WIDTH-1:0] r_out_d;
  logic             r_out_ovf;
  logic             r_out_zero;

  // The pipe moves whenever the last slot is empty or being drained
  assign w_adv    = ~r_out_v | out_ready;
  assign in_ready = w_adv;

  // Mode 01 always negates, mode 10 negates only negative words, 00/11 pass
  assign w_in_neg = (in_mode == 2'b01) | ((in_mode == 2'b10) & in_data[WIDTH-1]);

  // A word only enters on a real transfer; otherwise a bubble is shifted in
  assign w_v[0]    = in_valid & w_adv;
  assign w_neg[0]  = w_in_neg;
  assign w_seen[0] = 1'b0;
  assign w_d[0]    = in_data;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // w_run[j]: OR of every original bit below bit gi*SEG+j
      logic [SEG-1:0]   w_run;
      logic [WIDTH-1:0] w_res;

      // Ripple the OR-propagate through this segment and flip the bits that need it
      always_comb begin
        w_res    = w_d[gi];
        w_run[0] = w_seen[gi];
        for (int j = 1; j < SEG; j++) begin
          w_run[j] = w_run[j-1] | w_d[gi][gi*SEG+j-1];
        end
        for (int j = 0; j < SEG; j++) begin
          w_res[gi*SEG+j] = w_d[gi][gi*SEG+j] ^ (w_neg[gi] & w_run[j]);
        end
      end

      if (gi < STAGES - 1) begin : g_mid
        logic             r_v;
        logic             r_neg;
        logic             r_seen;
        logic [WIDTH-1:0] r_d;

        // Intermediate stage register: shifts with the pipe, holds on stall
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
          if (!sys_rst_n) begin
            r_v    <= 1'b0;
            r_neg  <= 1'b0;
            r_seen <= 1'b0;
            r_d    <= '0;
          end else if (w_adv) begin
            r_v    <= w_v[gi];
            r_neg  <= w_neg[gi];
            r_seen <= w_run[SEG-1] | w_d[gi][gi*SEG+SEG-1];
            r_d    <= w_res;
          end
        end

        assign w_v[gi+1]    = r_v;
        assign w_neg[gi+1]  = r_neg;
        assign w_seen[gi+1] = r_seen;
        assign w_d[gi+1]    = r_d;
      end else begin : g_last
        // Final stage: the MSB lives here, so overflow (10..0 negated) and zero are decided here
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
          if (!sys_rst_n) begin
            r_out_v    <= 1'b0;
            r_out_d    <= '0;
            r_out_ovf  <= 1'b0;
            r_out_zero <= 1'b0;
          end else if (w_adv) begin
            r_out_v    <= w_v[gi];
            r_out_d    <= w_res;
            r_out_ovf  <= w_neg[gi] & w_d[gi][WIDTH-1] & ~w_run[SEG-1];
            r_out_zero <= (w_res == '0);
          end
        end
      end
    end
  endgenerate

  assign out_valid = r_out_v;
  assign out_data  = r_out_d;
  assign out_ovf   = r_out_ovf;
  assign out_zero  = r_out_zero;

endmodule
